// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (A = CPU, B = DMA/loader) arbiter in front of a
// single-ported data memory. One access in flight; ack two cycles after the
// request is sampled; illegal (misaligned / out-of-range) accesses are
// answered with err and never reach the memory.
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie breaking;
// otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h10000000,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_we,
  input  logic        b_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] b_addr,
  input  logic [31:0] a_wdata,
  input  logic [31:0] b_wdata,
  output logic        a_ack,
  output logic        b_ack,
  output logic        a_err,
  output logic        b_err,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam int unsigned AW = 33;
  localparam logic [AW-1:0] ADDR_LO = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ADDR_HI = AW'(BASE_ADDR) + AW'(MEM_WORDS) * AW'(4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        cur_b;
  logic        cur_we;

  logic        sel_b_c;
  logic        sel_we_c;
  logic [31:0] sel_addr_c;
  logic [31:0] sel_wdata_c;
  logic        accept_c;
  logic        legal_c;

`ifdef DMEM_ARB_RR_EN
  logic last_b;

  // Tie goes to the port that did not win the previous selection.
  always_comb begin
    sel_b_c = b_req & (~a_req | ~last_b);
  end

  // Remember which port won the most recent IDLE selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (accept_c) begin
      last_b <= sel_b_c;
    end
  end
`else
  // Fixed priority: A wins any tie.
  always_comb begin
    sel_b_c = b_req & ~a_req;
  end
`endif

  // Mux the granted port's fields and decide acceptance and legality.
  // IDLE holds off while an ack is still showing so a request held through
  // its own ack cycle is not taken twice.
  always_comb begin
    sel_we_c    = sel_b_c ? b_we    : a_we;
    sel_addr_c  = sel_b_c ? b_addr  : a_addr;
    sel_wdata_c = sel_b_c ? b_wdata : a_wdata;
    accept_c    = (state == S_IDLE) & (a_req | b_req) & ~a_ack & ~b_ack;
    legal_c     = (sel_addr_c[1:0] == 2'b00) &&
                  ({1'b0, sel_addr_c} >= ADDR_LO) &&
                  ({1'b0, sel_addr_c} <  ADDR_HI);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c) state_nxt = legal_c ? S_ISSUE : S_ERR;
      S_ISSUE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered datapath: latch the grant, drive the memory for the ISSUE
  // cycle only, and produce the one-cycle ack on the granted port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_b    <= 1'b0;
      cur_we   <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rdata  <= 32'd0;
      b_rdata  <= 32'd0;
      mem_cs   <= 1'b0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 32'd0;
      mem_din  <= 32'd0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            cur_b  <= sel_b_c;
            cur_we <= sel_we_c;
            if (legal_c) begin
              mem_cs   <= 1'b1;
              mem_we   <= sel_we_c;
              mem_oe   <= ~sel_we_c;
              mem_addr <= sel_addr_c;
              mem_din  <= sel_wdata_c;
            end
          end
        end
        S_ISSUE: begin
          mem_cs   <= 1'b0;
          mem_we   <= 1'b0;
          mem_oe   <= 1'b0;
          mem_addr <= 32'd0;
          mem_din  <= 32'd0;
          if (cur_b) begin
            b_ack <= 1'b1;
            b_err <= 1'b0;
            if (!cur_we) b_rdata <= mem_dout;
          end else begin
            a_ack <= 1'b1;
            a_err <= 1'b0;
            if (!cur_we) a_rdata <= mem_dout;
          end
        end
        S_ERR: begin
          if (cur_b) begin
            b_ack   <= 1'b1;
            b_err   <= 1'b1;
            b_rdata <= 32'd0;
          end else begin
            a_ack   <= 1'b1;
            a_err   <= 1'b1;
            a_rdata <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps plus random bursts, each request
// queue-driven per port, checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h10000000;
  localparam int MW = 1024;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk, rst;
  logic        a_req, b_req, a_we, b_we;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic        a_ack, b_ack, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_cs, mem_oe, mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  dmem_arbiter #(.BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_err(a_err), .b_err(b_err),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: combinational read, write on the clock edge.
  logic [31:0] dmem [MW];
  logic [31:0] moff;
  assign moff     = mem_addr - BASE;
  assign mem_dout = (moff < 32'(4 * MW)) ? dmem[moff[11:2]] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (mem_cs && mem_we && moff < 32'(4 * MW)) dmem[moff[11:2]] = mem_din;
  end

  // Reference model state.
  logic [31:0] ref_mem [MW];
  logic [31:0] exp_rdata [2];
  txn_t        qa[$], qb[$];
  int          present [2];
  bit          presented [2];
  int          last_ack;
  bit          last_b;
  int          cyc;
  int          cs_cnt;
  logic [31:0] cs_addr, cs_din;
  logic        cs_we, cs_oe;
  bit          idle_bad;
  bit          abort_run;
  bit [3:0]    ord;
  int          ord_n;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return (x % 4 == 0) && (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * MW);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] w;
    r = $urandom_range(0, 99);
    w = BASE + 32'($urandom_range(0, MW - 1)) * 32'd4;
    if (r < 70)      return w;
    else if (r < 80) return w | 32'($urandom_range(1, 3));
    else if (r < 85) return BASE + 32'(4 * MW);
    else if (r < 90) return BASE - 32'd4;
    else if (r < 95) return BASE + 32'(4 * (MW - 1));
    else             return 32'h20000000 + w;
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic int qsize(input int p);
    return (p == 1) ? qb.size() : qa.size();
  endfunction

  function automatic txn_t qhead(input int p);
    return (p == 1) ? qb[0] : qa[0];
  endfunction

  function automatic logic ack_of(input int p);
    return (p == 1) ? b_ack : a_ack;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 1) ? b_err : a_err;
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    last_b = 1'b1;
    last_ack = -100;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    presented[0] = 1'b0;
    presented[1] = 1'b0;
    cs_cnt = 0;
    idle_bad = 1'b0;
  endtask

  // Check one completed transaction against the model and retire it.
  task automatic handle_ack(input int p);
    txn_t t;
    bit ca, cb, legal;
    int w, exp_cyc;
    if (qsize(p) == 0) begin
      chk("spurious_ack", 32'(ack_of(p)), 32'd0);
      return;
    end
    t  = qhead(p);
    ca = (qa.size() > 0) && presented[0] && (present[0] <= cyc - 2);
    cb = (qb.size() > 0) && presented[1] && (present[1] <= cyc - 2);
    if (ca && cb) w = RR ? (last_b ? 0 : 1) : 0;
    else          w = cb ? 1 : 0;
    chk("grant_port", 32'(p), 32'(w));
    exp_cyc = imax(last_ack + 3, present[p] + 2);
    chk("ack_cycle", 32'(cyc), 32'(exp_cyc));
    legal = is_legal(t.addr);
    chk("err", 32'(err_of(p)), 32'(!legal));
    if (legal) begin
      chk("mem_cs_cycles", 32'(cs_cnt), 32'd1);
      chk("mem_addr", cs_addr, t.addr);
      chk("mem_we", 32'(cs_we), 32'(t.we));
      chk("mem_oe", 32'(cs_oe), 32'(!t.we));
      if (t.we) begin
        chk("mem_din", cs_din, t.wdata);
        ref_mem[widx(t.addr)] = t.wdata;
      end else begin
        exp_rdata[p] = ref_mem[widx(t.addr)];
      end
    end else begin
      chk("mem_cs_cycles", 32'(cs_cnt), 32'd0);
      exp_rdata[p] = 32'd0;
    end
    chk("mem_idle_zero", 32'(idle_bad), 32'd0);
    chk("a_rdata", a_rdata, exp_rdata[0]);
    chk("b_rdata", b_rdata, exp_rdata[1]);
    if (ord_n < 4) ord[ord_n] = p[0];
    ord_n++;
    last_b = (p == 1);
    last_ack = cyc;
    presented[p] = 1'b0;
    cs_cnt = 0;
    idle_bad = 1'b0;
    if (p == 1) void'(qb.pop_front());
    else        void'(qa.pop_front());
  endtask

  // One negedge: record memory activity, check acks, detect missing acks.
  task automatic observe();
    bit got;
    int earliest;
    tick();
    if (mem_cs) begin
      cs_cnt++;
      cs_addr = mem_addr; cs_din = mem_din; cs_we = mem_we; cs_oe = mem_oe;
    end else if (mem_we || mem_oe || mem_addr != 32'd0 || mem_din != 32'd0) begin
      idle_bad = 1'b1;
    end
    if (a_ack && b_ack) chk("single_ack", 32'(b_ack), 32'd0);
    got = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (ack_of(p)) begin
        handle_ack(p);
        got = 1'b1;
      end
    end
    if (!got && (presented[0] || presented[1])) begin
      earliest = 1 << 30;
      for (int p = 0; p < 2; p++)
        if (presented[p] && present[p] + 2 < earliest) earliest = present[p] + 2;
      earliest = imax(earliest, last_ack + 3);
      if (cyc > earliest) begin
        chk("missing_ack", 32'(a_ack | b_ack), 32'd1);
        abort_run = 1'b1;
      end
    end
  endtask

  // Present each queue head on its port; idle ports get random fields.
  task automatic drive();
    txn_t t;
    a_req = (qa.size() > 0);
    b_req = (qb.size() > 0);
    if (a_req) begin t = qa[0]; a_we = t.we; a_addr = t.addr; a_wdata = t.wdata; end
    else begin a_we = 1'($urandom); a_addr = $urandom; a_wdata = $urandom; end
    if (b_req) begin t = qb[0]; b_we = t.we; b_addr = t.addr; b_wdata = t.wdata; end
    else begin b_we = 1'($urandom); b_addr = $urandom; b_wdata = $urandom; end
    for (int p = 0; p < 2; p++) begin
      if (qsize(p) > 0 && !presented[p]) begin
        presented[p] = 1'b1;
        present[p] = cyc;
      end
    end
  endtask

  task automatic run_queues();
    int n;
    n = 0;
    abort_run = 1'b0;
    drive();
    while ((qa.size() > 0 || qb.size() > 0) && !abort_run && n < 400) begin
      observe();
      drive();
      n++;
    end
    if (abort_run || n >= 400) begin
      chk("queue_drain", 32'(qa.size() + qb.size()), 32'd0);
      qa.delete(); qb.delete();
      presented[0] = 1'b0; presented[1] = 1'b0;
      drive();
    end
    for (int i = 0; i < 3; i++) observe();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ord_obs;
    cyc = 0; ord_n = 0; ord = 4'd0;
    for (int i = 0; i < MW; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[3] = 32'hDEADBEEF;
    ref_mem[3] = 32'hDEADBEEF;
    model_reset();
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = 32'd0; b_addr = 32'd0; a_wdata = 32'd0; b_wdata = 32'd0;

    // Reset state.
    tick(); tick();
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_err", 32'(b_err), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // Single read of a preloaded word, with exact ISSUE-cycle checks.
    tick();
    qa.push_back(mk(1'b0, 32'h1000000c, 32'd0));
    drive();
    observe();
    chk("rd_issue_cs", 32'(mem_cs), 32'd1);
    chk("rd_issue_oe", 32'(mem_oe), 32'd1);
    drive();
    run_queues();
    chk("rd_deadbeef", a_rdata, 32'hDEADBEEF);

    // B write then read back; A outputs checked at every ack by the model.
    qb.push_back(mk(1'b1, 32'h10000028, 32'h0000FF28));
    qb.push_back(mk(1'b0, 32'h10000028, 32'd0));
    run_queues();
    chk("wr_rd_b", b_rdata, 32'h0000FF28);
    chk("wr_rd_a_hold", a_rdata, 32'hDEADBEEF);

    // Error cases and range boundaries.
    qa.push_back(mk(1'b0, 32'h10000026, 32'd0));
    qa.push_back(mk(1'b0, 32'h10001000, 32'd0));
    run_queues();
    chk("err_rdata", a_rdata, 32'd0);
    qb.push_back(mk(1'b0, BASE + 32'(4 * (MW - 1)), 32'd0));
    qb.push_back(mk(1'b1, BASE - 32'd4, 32'h12345678));
    run_queues();

    // Tie: both ports hold requests for two accesses each.
    ord_n = 0;
    qa.push_back(mk(1'b0, BASE + 32'h100, 32'd0));
    qa.push_back(mk(1'b0, BASE + 32'h104, 32'd0));
    qb.push_back(mk(1'b0, BASE + 32'h200, 32'd0));
    qb.push_back(mk(1'b0, BASE + 32'h204, 32'd0));
    run_queues();
    ord_obs = 32'(ord);
    chk("tie_count", 32'(ord_n), 32'd4);
    chk("tie_order", ord_obs, RR ? 32'b1010 : 32'b1100);

    // Reset during ISSUE of an A read: no ack, everything cleared.
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = BASE + 32'h40; a_wdata = 32'd0;
    tick();
    chk("rst_mid_cs", 32'(mem_cs), 32'd1);
    rst = 1'b1;
    b_req = 1'b1; b_we = 1'b0; b_addr = BASE + 32'h44;
    tick();
    chk("rst_mid_a_ack", 32'(a_ack), 32'd0);
    chk("rst_mid_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mid_mem_oe", 32'(mem_oe), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_a_rdata", a_rdata, 32'd0);
    chk("rst_mid_b_rdata", b_rdata, 32'd0);
    tick();
    chk("rst_hold_a_ack", 32'(a_ack), 32'd0);
    chk("rst_hold_b_ack", 32'(b_ack), 32'd0);
    chk("rst_hold_mem_cs", 32'(mem_cs), 32'd0);
    rst = 1'b0;
    model_reset();
    qa.push_back(mk(1'b0, BASE + 32'h40, 32'd0));
    run_queues();

    // Random bursts on both ports.
    for (int k = 0; k < 20; k++) begin
      int na, nb;
      na = $urandom_range(0, 4);
      nb = $urandom_range(0, 4);
      for (int i = 0; i < na; i++) qa.push_back(mk(1'($urandom), rand_addr(), $urandom));
      for (int i = 0; i < nb; i++) qb.push_back(mk(1'($urandom), rand_addr(), $urandom));
      run_queues();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10000000: byte address of data-memory word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words in the backing data memory.
REQ-003 SHALL have ports, in this order:
- clk  input  1: single clock; all state updates on rising edge.
- rst  input  1: synchronous, active-high reset.
- a_req / b_req  input  1: access request from port A (CPU load/store) / port B (DMA/loader).
- a_we / b_we  input  1: 1 = write, 0 = read.
- a_addr / b_addr  input  32: byte address.
- a_wdata / b_wdata  input  32: write data.
- a_ack / b_ack  output  1: one-cycle completion pulse.
- a_err / b_err  output  1: valid with ack; access rejected.
- a_rdata / b_rdata  output  32: read data; valid with ack.
- mem_cs, mem_oe, mem_we  output  1: data-memory chip select, output enable, write enable.
- mem_addr  output  32: data-memory byte address.
- mem_din  output  32: data-memory write data.
- mem_dout  input  32: data-memory read data, valid in the same cycle as mem_cs/mem_oe.

Function
REQ-004 SHALL implement the FSM states IDLE, ISSUE, RESP and ERR.
REQ-005 IDLE: if any req is high, SHALL select a port (REQ-012), latch its we/addr/wdata, and go to ISSUE if the access is legal, else to ERR; otherwise SHALL stay in IDLE.
REQ-006 An access SHALL be legal only if addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS.
REQ-007 ISSUE: SHALL drive mem_cs=1, mem_we=latched we, mem_oe=~latched we, mem_addr=latched addr and mem_din=latched wdata for exactly one cycle. On a read it SHALL capture mem_dout into the selected port's rdata register at the end of that cycle. It SHALL then go to RESP.
REQ-008 RESP: SHALL pulse the selected port's ack for one cycle with err=0, then go to IDLE.
REQ-009 ERR: SHALL pulse the selected port's ack with err=1 and rdata=0, SHALL NOT assert mem_cs, then go to IDLE.
REQ-010 Outside ISSUE, mem_cs, mem_we and mem_oe SHALL be 0, and mem_addr and mem_din SHALL be 0.
REQ-011 Latency: req sampled in IDLE at cycle N SHALL produce ack at cycle N+2. At most one access SHALL be in flight; sustained throughput is one access per 3 cycles.
REQ-012 When only one req is high, that port SHALL be selected. Simultaneous requests SHALL be resolved per REQ-019/REQ-020.
REQ-013 A requester SHALL hold req and its request fields stable until ack. A req still high in the cycle after ack SHALL be treated as a new request.
REQ-014 A write SHALL leave the port's rdata unchanged. The unselected port's ack, err and rdata SHALL be unchanged.
REQ-015 Changes to request fields after the IDLE latch SHALL NOT affect the access in flight.

Reset
REQ-016 With rst high at a rising edge, the state SHALL become IDLE, all ack/err/rdata outputs SHALL become 0, all mem_* outputs SHALL become 0, and the last-grant register SHALL become B.
REQ-017 Reset asserted in ISSUE, RESP or ERR SHALL abort the access, and no ack SHALL be issued for it. A write already presented in ISSUE is not rolled back.
REQ-018 Requests present while rst is high SHALL be ignored. Arbitration SHALL resume on the first edge with rst low.

Configuration
REQ-019 With macro DMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the port not granted last (round-robin). The last-grant register SHALL update on each IDLE selection, so after reset A wins the first tie.
REQ-020 Without DMEM_ARB_RR_EN, port A SHALL always win ties (fixed priority), and the last-grant register SHALL be absent.

Verification
REQ-021 Single read: preload word at 32'h1000000c = 32'hDEADBEEF; a_req, a_we=0, a_addr=32'h1000000c at cycle N -> mem_cs=1, mem_oe=1 at N+1; a_ack=1, a_err=0, a_rdata=32'hDEADBEEF at N+2.
REQ-022 Write then read: b writes 32'h0000FF28 to 32'h10000028 -> b_ack after 2 cycles; b then reads 32'h10000028 -> b_rdata=32'h0000FF28, and a_* outputs are unchanged throughout.
REQ-023 Tie: a_req and b_req held high together for 2 accesses each -> with DMEM_ARB_RR_EN the ack order is A, B, A, B; without it the order is A, A, then B, B.
REQ-024 Errors: a_addr=32'h10000026 (misaligned) and a_addr=32'h10001000 (out of range, MEM_WORDS=1024) -> a_ack=1, a_err=1, a_rdata=0 at N+2; mem_cs stays 0.
REQ-025 Reset mid-access: assert rst during ISSUE of an A read -> no a_ack; all outputs 0 at the next edge; a new A request after release completes normally with ack at N+2.
